tap_judge: RTL and testbench

Per-lane tap judge for the rhythm game: conditions one active-low push button, then judges each press against the note currently at the lane's target position. It sits between the lane shift register (upstream: supplies `note_at_target` and `note_tick`) and `score_display` (downstream: consumes `score`). It replaces the edge-triggered tap logic with a single-clock synchronous design, and adds debounce, one-hit-per-note, and missed-note penalties.

---
 rtl/tap_judge_if.sv | 25 ++
 rtl/tap_judge.sv | 121 ++++++++++++
 tb/tb_tap_judge.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_judge_if.sv
// Lane-side bundle for tap_judge: button, game control, note feed and judge results.
interface tap_judge_if;
  localparam int unsigned SCORE_W = 5;

  logic               key_n;
  logic               running;
  logic               clear;
  logic               note_tick;
  logic               note_at_target;
  logic [SCORE_W-1:0] score;
  logic               key_down;
  logic               hit_pulse;
  logic               wrong_pulse;
  logic               miss_pulse;

  modport master (
    output key_n, running, clear, note_tick, note_at_target,
    input  score, key_down, hit_pulse, wrong_pulse, miss_pulse
  );

  modport slave (
    input  key_n, running, clear, note_tick, note_at_target,
    output score, key_down, hit_pulse, wrong_pulse, miss_pulse
  );
endinterface

// File: rtl/tap_judge.sv
// Per-lane tap judge: synchronizes and debounces the key, then scores each press
// against the armed note, penalizing wrong taps and notes that pass untapped.
module tap_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input logic        clk,
  input logic        reset,
  tap_judge_if.slave bus
);
  localparam int unsigned        SCORE_W   = 5;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               sync_1;
  logic               sync_2;
  logic               pressed_s;
  logic [CNT_W-1:0]   cnt;
  logic               key_down;
  logic               key_down_q;
  logic               press;
  logic               armed;
  logic               armed_nxt;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] score_nxt;
  logic               hit;
  logic               hit_nxt;
  logic               wrong;
  logic               wrong_nxt;
  logic               miss;
  logic               miss_nxt;

  // Synchronizer idles in the released (high) state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= bus.key_n;
      sync_2 <= sync_1;
    end
  end

  assign pressed_s = ~sync_2;

  // A level is accepted only after it disagrees with key_down for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      key_down   <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      key_down_q <= key_down;
      if (pressed_s == key_down) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_down <= pressed_s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = key_down & ~key_down_q;

  // Press is judged against the outgoing window before a tick re-arms the new note.
  always_comb begin
    score_nxt = score;
    armed_nxt = armed;
    hit_nxt   = 1'b0;
    wrong_nxt = 1'b0;
    miss_nxt  = 1'b0;
    if (bus.clear) begin
      score_nxt = '0;
      armed_nxt = 1'b0;
    end else if (!bus.running) begin
      armed_nxt = 1'b0;
    end else begin
      if (press) begin
        if (armed) begin
          hit_nxt   = 1'b1;
          armed_nxt = 1'b0;
          if (score != SCORE_MAX) score_nxt = score + SCORE_W'(1);
        end else begin
          wrong_nxt = 1'b1;
          score_nxt = (score > SCORE_W'(2)) ? score - SCORE_W'(2) : '0;
        end
      end
      if (bus.note_tick) begin
        if (armed_nxt) begin
          miss_nxt  = 1'b1;
          score_nxt = (score != '0) ? score - SCORE_W'(1) : '0;
        end
        armed_nxt = bus.note_at_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= '0;
      armed <= 1'b0;
      hit   <= 1'b0;
      wrong <= 1'b0;
      miss  <= 1'b0;
    end else begin
      score <= score_nxt;
      armed <= armed_nxt;
      hit   <= hit_nxt;
      wrong <= wrong_nxt;
      miss  <= miss_nxt;
    end
  end

  assign bus.score       = score;
  assign bus.key_down    = key_down;
  assign bus.hit_pulse   = hit;
  assign bus.wrong_pulse = wrong;
  assign bus.miss_pulse  = miss;
endmodule

// File: tb/tb_tap_judge.sv
// Scoreboard bench for tap_judge: stimulus pushes expected judge events, a monitor pops them.
`timescale 1ns/1ps
module tb_tap_judge;
  localparam int unsigned D       = 4;
  localparam int unsigned GAP     = D + 2;
  localparam int          SCHED_N = 16384;

  typedef struct {
    logic [2:0] kind;   // {hit, wrong, miss}
    int         score;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tap_judge_if bus();

  tap_judge #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  exp_t exp_q[$];
  bit   key_plan[$];
  bit   press_sched[SCHED_N];
  int   cyc;
  int   m_score;
  bit   m_armed;
  bit   kd_seen;
  int   checks;
  int   errors;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference judge: one edge of the game rules, in plain integer arithmetic.
  task automatic model_edge(input bit p, input bit tick, input bit nat, input bit clr);
    bit   a;
    bit   h = 1'b0;
    bit   w = 1'b0;
    bit   m = 1'b0;
    exp_t e;
    if (clr) begin
      m_score = 0;
      m_armed = 1'b0;
    end else if (!bus.running) begin
      m_armed = 1'b0;
    end else begin
      a = m_armed;
      if (p) begin
        if (a) begin
          h = 1'b1;
          m_score = (m_score + 1 > 31) ? 31 : m_score + 1;
          a = 1'b0;
        end else begin
          w = 1'b1;
          m_score = (m_score - 2 < 0) ? 0 : m_score - 2;
        end
      end
      if (tick) begin
        if (a) begin
          m = 1'b1;
          m_score = (m_score - 1 < 0) ? 0 : m_score - 1;
        end
        a = nat;
      end
      m_armed = a;
    end
    if (h || w || m) begin
      e.kind  = {h, w, m};
      e.score = m_score;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit tick, input bit nat, input bit clr);
    bit p;
    if (key_plan.size() > 0) bus.key_n = key_plan.pop_front();
    else                     bus.key_n = 1'b1;
    bus.note_tick      = tick;
    bus.note_at_target = nat;
    bus.clear          = clr;
    p = press_sched[cyc];
    press_sched[cyc] = 1'b0;
    model_edge(p, tick, nat, clr);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.key_down) kd_seen = 1'b1;
  endtask

  // Key held low for len edges starting at edge cyc, then released for a settling gap.
  task automatic plan_press(input int len);
    if (len >= int'(D)) press_sched[cyc + 2 + int'(D)] = 1'b1;
    repeat (len) key_plan.push_back(1'b0);
    repeat (GAP + $urandom_range(0, 3)) key_plan.push_back(1'b1);
  endtask

  task automatic do_press(input int len);
    plan_press(len);
    while (key_plan.size() > 0) step(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [2:0] k;
    exp_t       e;
    if (!reset) begin
      k = {bus.hit_pulse, bus.wrong_pulse, bus.miss_pulse};
      if (k != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'(k), 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'(k), int'(e.kind));
          check("pulse_score", int'(bus.score), e.score);
        end
      end
    end
  end

  initial begin
    int judge;
    checks = 0;
    errors = 0;
    cyc = 0;
    m_score = 0;
    m_armed = 1'b0;
    kd_seen = 1'b0;
    reset = 1'b1;
    bus.key_n = 1'b1;
    bus.running = 1'b1;
    bus.clear = 1'b0;
    bus.note_tick = 1'b0;
    bus.note_at_target = 1'b0;
    #12;
    check("reset_score", int'(bus.score), 0);
    check("reset_key_down", int'(bus.key_down), 0);
    check("reset_pulses", int'({bus.hit_pulse, bus.wrong_pulse, bus.miss_pulse}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Short glitch never reaches key_down.
    kd_seen = 1'b0;
    plan_press(3);
    while (key_plan.size() > 0) step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("glitch_key_down", int'(kd_seen), 0);

    // Held key: key_down rises after edge E+5, one wrong tap since nothing is armed.
    plan_press(10);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("debounce_early", int'(bus.key_down), 0);
    step(1'b0, 1'b0, 1'b0);
    check("debounce_late", int'(bus.key_down), 1);
    while (key_plan.size() > 0) step(1'b0, 1'b0, 1'b0);

    // Hit, then second press in the same window is wrong.
    step(1'b1, 1'b1, 1'b0);
    do_press(6);
    check("hit_score", int'(bus.score), 1);
    do_press(5);
    check("second_press_score", int'(bus.score), 0);

    // Miss and floor at zero.
    step(1'b1, 1'b1, 1'b0);
    do_press(5);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("miss_score", int'(bus.score), 0);
    do_press(5);
    check("floor_score", int'(bus.score), 0);

    // Saturation at 31.
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 1'b1, 1'b0);
      do_press(int'(D) + int'($urandom_range(0, 3)));
    end
    check("sat_score", int'(bus.score), 31);

    // Press and tick on the same edge: press judged against the old note.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    judge = cyc + 2 + int'(D);
    plan_press(5);
    while (cyc < judge) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    while (key_plan.size() > 0) step(1'b0, 1'b0, 1'b0);
    do_press(5);
    check("simul_score", int'(bus.score), 2);

    // Paused: nothing scores.
    bus.running = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    do_press(5);
    step(1'b1, 1'b1, 1'b0);
    do_press(6);
    check("paused_score", int'(bus.score), 2);
    bus.running = 1'b1;
    step(1'b1, 1'b0, 1'b0);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      bit t;
      bit n;
      bit c;
      if (bus.running) begin
        if ($urandom_range(0, 99) < 2) bus.running = 1'b0;
      end else if ($urandom_range(0, 99) < 15) begin
        bus.running = 1'b1;
      end
      t = ($urandom_range(0, 4) == 0);
      n = $urandom_range(0, 1) != 0;
      c = ($urandom_range(0, 199) == 0);
      if (key_plan.size() == 0 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) plan_press(int'($urandom_range(1, D - 1)));
        else                           plan_press(int'(D) + int'($urandom_range(0, 6)));
      end
      step(t, n, c);
    end
    bus.running = 1'b1;
    while (key_plan.size() > 0) step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("random_score", int'(bus.score), m_score);

    // Score 7, key held while paused, then asynchronous reset.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0);
      do_press(5);
    end
    check("pre_reset_score", int'(bus.score), 7);
    bus.running = 1'b0;
    plan_press(30);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    check("held_key_down", int'(bus.key_down), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_score", int'(bus.score), 0);
    check("async_reset_key_down", int'(bus.key_down), 0);
    key_plan.delete();
    for (int i = 0; i < SCHED_N; i++) press_sched[i] = 1'b0;
    m_score = 0;
    m_armed = 1'b0;
    bus.key_n = 1'b1;
    bus.running = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("post_reset_score", int'(bus.score), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
